flag_branch_unit: RTL

- Downstream consumer of the ALU status outputs: zero from the NOR/AND zero-detect tree, plus negative, carry and overflow.
- Holds the architectural NZCV flag register, updated only by flag-setting instructions (ADDS/SUBS).
- Resolves conditional branches (B.cond, CBZ, CBNZ) for the pipelined CPU, with a one-cycle registered result.
- Forwards same-cycle ALU flags to a branch resolving in the same cycle, so a flag-setting instruction followed directly by B.cond needs no stall.

---
 rtl/flag_pkg.sv | 22 ++
 rtl/cond_eval.sv | 43 ++++
 rtl/flag_branch_unit.sv | 73 +++++++
 3 files changed

// File: rtl/flag_pkg.sv
// Shared definitions for the flag/branch unit: NZCV layout, widths, B.cond codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flag_pkg;

  localparam int FLAG_W = 4;
  localparam int COND_W = 4;

  // NZCV bit positions inside the flag vector (N is the MSB).
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// B.cond decoder: maps a condition code and an NZCV vector to a taken decision.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond (condition code), eff (NZCV to test), taken (condition holds).
module cond_eval
  import flag_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] eff,
  output logic              taken
);

  logic n, z, c, v;

  assign n = eff[N_IDX];
  assign z = eff[Z_IDX];
  assign c = eff[C_IDX];
  assign v = eff[V_IDX];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      EQ: taken = z;
      NE: taken = ~z;
      HS: taken = c;
      LO: taken = ~c;
      MI: taken = n;
      PL: taken = ~n;
      VS: taken = v;
      VC: taken = ~v;
      HI: taken = c & ~z;
      LS: taken = ~c | z;
      GE: taken = (n == v);
      LT: taken = (n != v);
      GT: taken = ~z & (n == v);
      LE: taken = z | (n != v);
      AL: taken = 1'b1;
      NV: taken = 1'b1;  // NV behaves as always-taken on ARMv8
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus B.cond/CBZ/CBNZ resolution with same-cycle ALU flag bypass.
// Latency: one cycle from request to registered br_done/br_taken; flag write lands on the next edge.
// Backpressure: stall freezes flags and drops the request (upstream re-presents it); flush kills the cycle.
// Ports: clk, reset (async active-low); alu_* live status; ex_valid/set_flags/stall/flush pipeline
//        controls; br_req+cond and cbz_req+is_cbnz requests; flags_q/flags_valid state; br_done/br_taken result.
module flag_branch_unit
  import flag_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              ex_valid,
  input  logic              set_flags,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_req,
  input  logic [COND_W-1:0] cond,
  input  logic              cbz_req,
  input  logic              is_cbnz,
  output logic [FLAG_W-1:0] flags_q,
  output logic              flags_valid,
  output logic              br_done,
  output logic              br_taken
);

  logic [FLAG_W-1:0] live;
  logic [FLAG_W-1:0] eff;
  logic              wr;
  logic              fire;
  logic              bcond_taken;
  logic              result;

  assign live = {alu_negative, alu_zero, alu_carry, alu_overflow};
  assign wr   = set_flags & ex_valid & ~flush;

  // Bypass ignores stall on purpose: the flags a branch sees in this cycle
  // are those of the instruction in EX, whether or not they commit now.
  assign eff  = wr ? live : flags_q;

  assign fire = (br_req | cbz_req) & ~stall & ~flush;

  cond_eval u_cond_eval (
    .cond  (cond),
    .eff   (eff),
    .taken (bcond_taken)
  );

  // br_req has priority if both request types are (illegally) raised.
  // CBZ/CBNZ looks at the live zero only, never at the flag register.
  assign result = br_req ? bcond_taken : (alu_zero ^ is_cbnz);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q     <= '0;
      flags_valid <= 1'b0;
      br_done     <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      if (wr && !stall) begin
        flags_q     <= live;
        flags_valid <= 1'b1;
      end
      br_done <= fire;
      if (fire) begin
        br_taken <= result;
      end
    end
  end

endmodule
